// File: rtl/pixel_stream_ctrl.sv
// Frame sequencer: walks a pixel memory in raster order and streams pixels over valid/ready.
// Define PIXEL_STREAM_CTRL_ZERO_PAD_EN to emit a zero border of PAD pixels around the image.
module pixel_stream_ctrl #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int PIXELWIDTH = 8,
  parameter int ADDRWIDTH  = 10,
  parameter int PAD        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDRWIDTH-1:0]  mem_addr,
  input  logic [PIXELWIDTH-1:0] mem_data,
  output logic [PIXELWIDTH-1:0] pix_out,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

`ifdef PIXEL_STREAM_CTRL_ZERO_PAD_EN
  localparam int OW = IMG_W + 2 * PAD;
  localparam int OH = IMG_H + 2 * PAD;
`else
  // PAD has no effect on the frame without padding.
  localparam int OW = IMG_W + 0 * PAD;
  localparam int OH = IMG_H + 0 * PAD;
`endif
  localparam int CW = $clog2(OW + 1);
  localparam int RW = $clog2(OH + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(OW - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(OH - 1);
  localparam logic [ADDRWIDTH-1:0] IMG_W_A = ADDRWIDTH'(IMG_W);

  state_t                state_q, state_d;
  logic [CW-1:0]         f_col_q, f_col_d, o_col_q, o_col_d;
  logic [RW-1:0]         f_row_q, f_row_d, o_row_q, o_row_d;
  logic                  ret_q;
  logic [PIXELWIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            cnt_q;
  logic                  done_q;
  logic                  issue, pop, push, f_last, o_eol, o_eof;
  logic [2:0]            occ;
  logic [PIXELWIDTH-1:0] push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && f_last) state_d = S_FLUSH;
      S_FLUSH: if (pop && o_eof) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PIXEL_STREAM_CTRL_ZERO_PAD_EN
  localparam logic [CW-1:0] PAD_C = CW'(PAD);
  localparam logic [RW-1:0] PAD_R = RW'(PAD);
  localparam logic [CW-1:0] END_C = CW'(PAD + IMG_W);
  localparam logic [RW-1:0] END_R = RW'(PAD + IMG_H);
  localparam logic [ADDRWIDTH-1:0] PAD_A = ADDRWIDTH'(PAD);
  logic border, pad_ret_q;
`endif

  always_comb begin
    pix_valid = (cnt_q != 2'd0);
    pop       = pix_valid && pix_ready;
    occ       = {1'b0, cnt_q} + {2'b00, ret_q};
    // Credit: never let buffered plus returning entries exceed the two slots.
    issue     = (state_q == S_RUN) && ((occ - {2'b00, pop}) < 3'd2);
    busy      = (state_q != S_IDLE);
    done      = done_q;
    dbg_state = state_q;
    f_last    = (f_col_q == LAST_COL) && (f_row_q == LAST_ROW);
    o_eol     = (o_col_q == LAST_COL);
    o_eof     = o_eol && (o_row_q == LAST_ROW);
    sof       = pix_valid && (o_col_q == '0) && (o_row_q == '0);
    eol       = pix_valid && o_eol;
    eof       = pix_valid && o_eof;
    pix_out   = pix_valid ? buf_q[rd_ptr_q] : '0;
    push      = ret_q;
`ifdef PIXEL_STREAM_CTRL_ZERO_PAD_EN
    border    = (f_row_q < PAD_R) || (f_row_q >= END_R) || (f_col_q < PAD_C) || (f_col_q >= END_C);
    mem_rd    = issue && !border;
    mem_addr  = mem_rd ? (ADDRWIDTH'(f_row_q) - PAD_A) * IMG_W_A + ADDRWIDTH'(f_col_q) - PAD_A : '0;
    push_data = pad_ret_q ? '0 : mem_data;
`else
    mem_rd    = issue;
    mem_addr  = ADDRWIDTH'(f_row_q) * IMG_W_A + ADDRWIDTH'(f_col_q);
    push_data = mem_data;
`endif
  end

  always_comb begin
    f_col_d = f_col_q;
    f_row_d = f_row_q;
    o_col_d = o_col_q;
    o_row_d = o_row_q;
    if (state_q == S_IDLE && start) begin
      f_col_d = '0;
      f_row_d = '0;
      o_col_d = '0;
      o_row_d = '0;
    end else begin
      if (issue) begin
        if (f_col_q == LAST_COL) begin
          f_col_d = '0;
          f_row_d = (f_row_q == LAST_ROW) ? '0 : f_row_q + 1'b1;
        end else begin
          f_col_d = f_col_q + 1'b1;
        end
      end
      if (pop) begin
        if (o_eol) begin
          o_col_d = '0;
          o_row_d = o_eof ? '0 : o_row_q + 1'b1;
        end else begin
          o_col_d = o_col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_col_q  <= '0;
      f_row_q  <= '0;
      o_col_q  <= '0;
      o_row_q  <= '0;
      ret_q    <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      done_q   <= 1'b0;
    end else begin
      f_col_q <= f_col_d;
      f_row_q <= f_row_d;
      o_col_q <= o_col_d;
      o_row_q <= o_row_d;
      // Border pixels ride the same one-cycle return stage so output order matches fetch order.
      ret_q   <= issue;
      done_q  <= (state_q == S_FLUSH) && pop && o_eof;
      if (push) begin
        buf_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef PIXEL_STREAM_CTRL_ZERO_PAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pad_ret_q <= 1'b0;
    else     pad_ret_q <= issue && border;
  end
`endif

endmodule
